// File: rtl/cache_snoop_ctrl.sv
// cache_snoop_ctrl: bus-side MSI snoop controller with a per-line coherence state/tag table.
// Optional SNOOP_STATS_EN adds saturating write-back and invalidation counters.
module cache_snoop_ctrl #(
    parameter int LINES = 4,
    parameter int IDX_W = 2,
    parameter int TAG_W = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   bus_valid,
    output logic                   bus_ready,
    input  logic [2:0]             bus_msg,
    input  logic [TAG_W+IDX_W-1:0] bus_addr,
    input  logic                   proc_we,
    input  logic [IDX_W-1:0]       proc_idx,
    input  logic [TAG_W-1:0]       proc_tag,
    input  logic [1:0]             proc_state,
    output logic                   wb_valid,
    output logic [TAG_W+IDX_W-1:0] wb_addr,
    input  logic                   wb_ready,
    output logic                   abort_mem,
    output logic                   snoop_hit,
    output logic                   proto_err,
    output logic                   busy,
    input  logic [IDX_W-1:0]       dbg_idx,
    output logic [1:0]             dbg_state,
    output logic [TAG_W-1:0]       dbg_tag
`ifdef SNOOP_STATS_EN
    ,
    output logic [7:0]             wb_count,
    output logic [7:0]             inv_count
`endif
);
    typedef enum logic [1:0] {IDLE, LOOKUP, WB, UPDATE} fsm_t;
    localparam logic [1:0] INV = 2'b00, EXC = 2'b01, SHR = 2'b10;
    localparam logic [2:0] RM = 3'd1, PI = 3'd2, WM = 3'd3;

    fsm_t             state, nxt;
    logic [1:0]       st [LINES];
    logic [TAG_W-1:0] tg [LINES];
    logic [2:0]       cap_msg;
    logic [TAG_W-1:0] cap_tag;
    logic [IDX_W-1:0] cap_idx;
    logic [1:0]       new_st;
    logic [1:0]       cur_st;
    logic             hit;
    logic             accept;
    logic             legal;

    assign cur_st    = st[cap_idx];
    assign hit       = (cur_st != INV) && (tg[cap_idx] == cap_tag);
    assign accept    = bus_valid && bus_ready;
    assign legal     = (bus_msg == RM) || (bus_msg == PI) || (bus_msg == WM);
    assign dbg_state = st[dbg_idx];
    assign dbg_tag   = tg[dbg_idx];

    always_ff @(posedge clock) begin
        state <= reset ? IDLE : nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = (accept && legal) ? LOOKUP : IDLE;
            LOOKUP:  nxt = !hit ? IDLE :
                           (cur_st == EXC) ? ((cap_msg == PI) ? IDLE : WB) :
                           ((cap_msg == RM) ? IDLE : UPDATE);
            WB:      nxt = wb_ready ? UPDATE : WB;
            default: nxt = IDLE;
        endcase
    end

    always_comb begin
        bus_ready = (state == IDLE) && !reset;
        busy      = state != IDLE;
        wb_valid  = state == WB;
        abort_mem = state == WB;
        wb_addr   = {cap_tag, cap_idx};
        snoop_hit = (state == LOOKUP) && hit;
        proto_err = (state == LOOKUP) && hit && (cur_st == EXC) && (cap_msg == PI);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) begin
                st[i] <= INV;
                tg[i] <= '0;
            end
            cap_msg <= '0;
            cap_tag <= '0;
            cap_idx <= '0;
            new_st  <= INV;
        end else begin
            if (accept) begin
                cap_msg <= bus_msg;
                cap_tag <= bus_addr[TAG_W+IDX_W-1:IDX_W];
                cap_idx <= bus_addr[IDX_W-1:0];
            end
            // processor writes only land while idle, so they never race an UPDATE
            if (state == IDLE && proc_we) begin
                st[proc_idx] <= (proc_state == 2'b11) ? INV : proc_state;
                tg[proc_idx] <= proc_tag;
            end
            if (state == LOOKUP)
                new_st <= (cur_st == EXC && cap_msg == RM) ? SHR : INV;
            if (state == UPDATE)
                st[cap_idx] <= new_st;
        end
    end

`ifdef SNOOP_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            wb_count  <= '0;
            inv_count <= '0;
        end else begin
            if (wb_valid && wb_ready && wb_count != 8'hFF)
                wb_count <= wb_count + 8'd1;
            if (state == UPDATE && new_st == INV && inv_count != 8'hFF)
                inv_count <= inv_count + 8'd1;
        end
    end
`endif
endmodule
